// File: rtl/map9v3_sched.sv
// Round-robin scheduler sharing one map9v3 engine among NUM_REQ requesters.
// Optional watchdog abort enabled by defining MAP9_SCHED_TIMEOUT_EN.
module map9v3_sched #(
  parameter int NUM_REQ        = 4,
  parameter int START_HOLD     = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [9*NUM_REQ-1:0]   req_n,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [8:0]             rsp_dp,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   eng_start,
  output logic [8:0]             eng_n,
  input  logic                   eng_done,
  input  logic [8:0]             eng_dp
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HW = $clog2(START_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(START_HOLD);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, RESP} state_t;

  state_t          state;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   owner;
  logic [HW-1:0]   hold;
  logic            any_req;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   cand;

  // Scan offsets from farthest to nearest so the first requester after last_grant wins.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    cand    = '0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((32'(last_grant) + k) % NUM_REQ);
      if (req[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
  end

`ifdef MAP9_SCHED_TIMEOUT_EN
  localparam logic [10:0] WD_LIM = 11'(TIMEOUT_CYCLES - 1);
  logic [10:0] wd;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      owner      <= '0;
      hold       <= '0;
      req_ack    <= '0;
      rsp_valid  <= '0;
      rsp_dp     <= '0;
      busy       <= 1'b0;
      eng_start  <= 1'b0;
      eng_n      <= '0;
`ifdef MAP9_SCHED_TIMEOUT_EN
      rsp_err    <= 1'b0;
      wd         <= '0;
`endif
    end else begin
      req_ack <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            req_ack[winner] <= 1'b1;
            owner           <= winner;
            eng_n           <= req_n[9*winner +: 9];
            eng_start       <= 1'b1;
            busy            <= 1'b1;
            hold            <= HW'(1);
            state           <= LAUNCH;
`ifdef MAP9_SCHED_TIMEOUT_EN
            wd              <= '0;
`endif
          end
        end
        LAUNCH: begin
          // Stay high until the engine has also dropped any done left from the last job.
          if (hold >= HOLD_LIM && !eng_done) begin
            eng_start <= 1'b0;
            state     <= RUN;
          end else if (hold < HOLD_LIM) begin
            hold <= hold + 1'b1;
          end
        end
        RUN: begin
          if (eng_done) begin
            rsp_dp           <= eng_dp;
            rsp_valid[owner] <= 1'b1;
            state            <= RESP;
          end
        end
        RESP: begin
          if (rsp_valid[owner] && rsp_ready[owner]) begin
            rsp_valid  <= '0;
            last_grant <= owner;
            busy       <= 1'b0;
            state      <= IDLE;
`ifdef MAP9_SCHED_TIMEOUT_EN
            rsp_err    <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
`ifdef MAP9_SCHED_TIMEOUT_EN
      // Placed after the case so an expiring watchdog overrides the LAUNCH/RUN updates.
      if ((state == LAUNCH) || (state == RUN && !eng_done)) begin
        if (wd == WD_LIM) begin
          eng_start        <= 1'b0;
          rsp_dp           <= '0;
          rsp_err          <= 1'b1;
          rsp_valid[owner] <= 1'b1;
          state            <= RESP;
        end else begin
          wd <= wd + 1'b1;
        end
      end
`endif
    end
  end

`ifndef MAP9_SCHED_TIMEOUT_EN
  // No watchdog in this build; TIMEOUT_CYCLES is only referenced to keep the parameter list uniform.
  assign rsp_err = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: doc/map9v3_sched.md
# map9v3_sched

Round-robin scheduler that shares one map9v3 engine among NUM_REQ requesters. It accepts a 9-bit N operand from the winning requester, launches the engine with a start pulse wide enough to pass the engine's two-flop start synchronizer, and waits for done. It then returns the 9-bit dp result to the owning requester over a valid/ready handshake. It sits between the client blocks and the single map9v3 instance.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- START_HOLD, 3, minimum cycles eng_start is held high (covers the engine's 2-flop sync plus edge detect)
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles (used only with MAP9_SCHED_TIMEOUT_EN)

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  level request per requester; held until req_ack
- req_n  in  9*NUM_REQ  operand of requester i in bits [9i+8:9i]; stable while req[i] is high
- req_ack  out  NUM_REQ  one-cycle pulse; operand captured
- rsp_valid  out  NUM_REQ  result pending for requester i; held until rsp_ready[i]
- rsp_ready  in  NUM_REQ  requester accepts its result
- rsp_dp  out  9  result data, valid with any rsp_valid bit
- rsp_err  out  1  result is a timeout abort; tied 0 when the macro is off
- busy  out  1  high in every state except IDLE
- eng_start  out  1  to map9v3 start
- eng_n  out  9  to map9v3 N
- eng_done  in  1  from map9v3 done
- eng_dp  in  9  from map9v3 dp

## Operation
- FSM states: IDLE, LAUNCH, RUN, RESP. All outputs are registered.
- IDLE:
  - eng_start=0; eng_done is ignored, including a stale high.
  - If any req bit is set, select the winner w round-robin, searching from last_grant+1 upward with wrap.
  - eng_n <= req_n[w], owner <= w, req_ack[w] pulses, go to LAUNCH.
- LAUNCH:
  - eng_start=1, hold counter increments.
  - Exit to RUN when hold >= START_HOLD and eng_done==0, i.e. the engine has dropped its previous done.
  - The first run after reset has done already low, so LAUNCH exits after exactly START_HOLD cycles.
- RUN:
  - eng_start=0.
  - When eng_done==1: rsp_dp <= eng_dp, rsp_valid[owner] <= 1, go to RESP.
- RESP:
  - Hold rsp_valid[owner] and rsp_dp until rsp_valid[owner] and rsp_ready[owner] are both high in the same cycle.
  - On that cycle: clear rsp_valid, last_grant <= owner, go to IDLE.
- Only one job is in flight. New requests wait in their req lines; no request is granted while busy.
- eng_n stays stable from LAUNCH through RESP.
- Reset values: state IDLE, last_grant = NUM_REQ-1 (so requester 0 wins first), and all outputs 0: req_ack, rsp_valid, rsp_dp, rsp_err, busy, eng_start, eng_n.

## Timing
- Cycle 0: IDLE samples req. Cycle 1: req_ack pulse, LAUNCH begins, eng_start rises.
- eng_start high time is max(START_HOLD, cycles until eng_done==0).
- eng_start is low for at least 1 cycle between launches, because RESP and IDLE each last at least 1 cycle; this guarantees a fresh rising edge at the engine.
- rsp_valid rises 1 cycle after eng_done is sampled high in RUN.
- rsp_ready may already be high when rsp_valid rises; the handshake completes in that first valid cycle.
- Earliest re-grant is the cycle after the handshake, which is back in IDLE.
- Simultaneous requests: one grant per job, strictly round-robin, so no requester starves.
- req[owner] dropping after ack has no effect. req[i] held across its own RESP is treated as a new request.
- Reset mid-operation: asynchronous clear of all state; eng_start drops immediately; any in-flight result is discarded.

## Configuration
- MAP9_SCHED_TIMEOUT_EN defined:
  - An 11-bit watchdog counts cycles spent in LAUNCH+RUN.
  - When the count reaches TIMEOUT_CYCLES: eng_start <= 0, rsp_dp <= 0, rsp_err <= 1, rsp_valid[owner] <= 1, go to RESP.
  - rsp_err clears on the handshake.
- MAP9_SCHED_TIMEOUT_EN undefined: no watchdog, rsp_err is constant 0, and RUN waits for eng_done indefinitely.

## Test plan
- Reset, req=0001, req_n0=9'h0A5, engine model raises done with dp=9'h15A after 40 cycles: req_ack=0001 at cycle 1, eng_start high exactly 3 cycles, rsp_valid=0001 with rsp_dp=9'h15A, busy low after the handshake.
- req=1111 held high continuously: grants occur in order 0,1,2,3,0. The second launch holds eng_start until the model drops its stale done.
- rsp_ready held low for 20 cycles: rsp_valid and rsp_dp stay stable, no new req_ack appears, and the handshake occurs on the cycle rsp_ready rises.
- reset_n pulsed low during RUN: all outputs read 0 during reset; after release, req1 pending wins before req2 (last_grant reset to NUM_REQ-1).
- Macro on, TIMEOUT_CYCLES=64, model never raises done: rsp_valid with rsp_err=1 and rsp_dp=0 at 64 cycles; next job proceeds normally with rsp_err=0.
- Stale eng_done=1 in IDLE with req=0: no launch occurs and busy stays 0.
